// File: rtl/student_pkg.sv
// student_pkg: shared types for student_tlul_host.
//   state_e  : host FSM states (IDLE, REQ, WAIT, RSP)
//   TL_SIZE  : a_size value for full 32-bit word accesses (log2 of 4 bytes)
package student_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    localparam logic [1:0] TL_SIZE = 2'd2;

endpackage

// File: rtl/tlul_pkg.sv
// tlul_pkg: minimal TileLink Uncached Lightweight (TL-UL) types for a 32-bit bus.
//   tl_h2d_t : host-to-device A channel plus d_ready
//   tl_d2h_t : device-to-host D channel plus a_ready
//   tl_a_op_e / tl_d_op_e : A and D channel opcodes
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    localparam logic [15:0] TL_A_USER_DEFAULT = '0;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [0:0]  d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/student_tlul_host.sv
// student_tlul_host: single-outstanding TL-UL host adapter.
// Turns a simple valid/ready command (we/addr/wdata/be) into one TL-UL
// A-channel request, waits for the D-channel beat and presents it as a
// valid/ready response.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   req_valid_i/req_ready_o  command handshake (ready only in IDLE)
//   req_we_i, req_addr_i, req_wdata_i, req_be_i  command fields
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_rdata_o, rsp_err_o   response data (0 on writes/errors) and error
//   tl_o / tl_i              TL-UL host-to-device / device-to-host buses
//
// Build option: define STUDENT_TLUL_HOST_TIMEOUT_EN to give up waiting for
// the D beat after TimeoutCycles cycles in WAIT and report an error.
module student_tlul_host
    import tlul_pkg::*;
    import student_pkg::*;
#(
    parameter logic [7:0]  SourceId      = 8'd0,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic         req_we_i,
    input  logic [31:0]  req_addr_i,
    input  logic [31:0]  req_wdata_i,
    input  logic [3:0]   req_be_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [31:0]  rsp_rdata_o,
    output logic         rsp_err_o,
    output tl_h2d_t      tl_o,
    input  tl_d2h_t      tl_i
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [29:0] addr_q, addr_d;   // word address; byte offset is never sent
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        d_bad;

`ifdef STUDENT_TLUL_HOST_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
`else
    localparam int unsigned unused_timeout_cycles = TimeoutCycles;
`endif

    // D-channel fields this host never looks at.
    logic unused_d_fields;
    assign unused_d_fields = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};

    // A beat is bad if flagged, misrouted, or of the wrong kind for the request.
    assign d_bad = tl_i.d_error
                 || (tl_i.d_source != SourceId)
                 || (tl_i.d_opcode != (we_q ? AccessAck : AccessAckData));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef STUDENT_TLUL_HOST_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef STUDENT_TLUL_HOST_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef STUDENT_TLUL_HOST_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i[31:2];
                    wdata_d = req_wdata_i;
                    be_d    = req_be_i;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (tl_i.a_ready) begin
                    state_d = ST_WAIT;
`ifdef STUDENT_TLUL_HOST_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_WAIT: begin
                // A beat arriving in the same cycle as the timeout still wins.
                if (tl_i.d_valid) begin
                    err_d   = d_bad;
                    rdata_d = (we_q || d_bad) ? '0 : tl_i.d_data;
                    state_d = ST_RSP;
                end
`ifdef STUDENT_TLUL_HOST_TIMEOUT_EN
                else if (cnt_q == 16'(TimeoutCycles - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_RSP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            ST_RSP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = (state_q == ST_REQ);
        tl_o.a_opcode  = !we_q ? Get : ((be_q == 4'hF) ? PutFullData : PutPartialData);
        tl_o.a_param   = '0;
        tl_o.a_size    = TL_SIZE;
        tl_o.a_source  = SourceId;
        tl_o.a_address = {addr_q, 2'b00};
        tl_o.a_mask    = we_q ? be_q : 4'hF;
        tl_o.a_data    = we_q ? wdata_q : '0;
        tl_o.a_user    = TL_A_USER_DEFAULT;
        tl_o.d_ready   = (state_q != ST_RSP);
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RSP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: doc/student_tlul_host.md
STUDENT_TLUL_HOST -- requirements
Module: student_tlul_host

Interface
REQ-001 SHALL have parameter SourceId, default 0, 8-bit a_source value driven on every request.
REQ-002 SHALL have parameter TimeoutCycles, default 255, response-wait limit in clk_i cycles (1..65535).
REQ-003 SHALL have clk_i  input  1  clock, rising edge.
REQ-004 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have req_valid_i  input  1  command valid.
REQ-006 SHALL have req_ready_o  output  1  command accepted when high with req_valid_i.
REQ-007 SHALL have req_we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have req_addr_i  input  32  byte address.
REQ-009 SHALL have req_wdata_i  input  32  write data.
REQ-010 SHALL have req_be_i  input  4  write byte enables.
REQ-011 SHALL have rsp_valid_o  output  1  response valid.
REQ-012 SHALL have rsp_ready_i  input  1  response consumed.
REQ-013 SHALL have rsp_rdata_o  output  32  read data (0 for writes).
REQ-014 SHALL have rsp_err_o  output  1  bus, protocol or timeout error.
REQ-015 SHALL have tl_o  output  tlul_pkg::tl_h2d_t  TL-UL A-channel and d_ready.
REQ-016 SHALL have tl_i  input  tlul_pkg::tl_d2h_t  TL-UL D-channel and a_ready.

Function
REQ-017 SHALL implement FSM IDLE, REQ, WAIT, RSP; exactly one transaction outstanding.
REQ-018 IDLE: req_ready_o=1; on req_valid_i capture we/addr/wdata/be, go REQ next cycle.
REQ-019 REQ: a_valid=1, fields held stable from captured values; on a_ready go WAIT.
REQ-020 A-channel fields: a_address={addr[31:2],2'b00}; a_size=2; a_param=0; a_source=SourceId; a_user=default.
REQ-021 Read: a_opcode=Get, a_mask=4'hF, a_data=0; write: PutFullData if be==4'hF else PutPartialData (including be==0), a_mask=be, a_data=wdata.
REQ-022 d_ready=1 in IDLE, REQ, WAIT; 0 in RSP; D beats accepted in IDLE or REQ are stray and discarded.
REQ-023 WAIT: on d_valid capture d_data and error, go RSP.
REQ-024 Captured error = d_error OR d_source!=SourceId OR opcode mismatch (read expects AccessAckData, write expects AccessAck).
REQ-025 RSP: rsp_valid_o=1, rsp_rdata_o/rsp_err_o stable; on rsp_ready_i go IDLE.
REQ-026 rsp_rdata_o SHALL be 0 for writes and for any errored response.
REQ-027 Best-case latency: req accept at cycle 0 -> a_valid cycle 1 -> d_valid cycle 2 -> rsp_valid_o cycle 3.
REQ-028 req_ready_o SHALL be 0 outside IDLE; no back-to-back acceptance in RSP->IDLE cycle.

Reset
REQ-029 Reset SHALL force IDLE, a_valid=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, req_ready_o=1 after release, timeout counter 0.
REQ-030 Reset mid-transaction SHALL abandon it; no response emitted; late D beat discarded in IDLE.

Configuration
REQ-031 Macro STUDENT_TLUL_HOST_TIMEOUT_EN defined: WAIT counts cycles; at TimeoutCycles without d_valid go RSP with rsp_err_o=1, rsp_rdata_o=0; late beat discarded per REQ-022.
REQ-032 Macro undefined: no counter; WAIT persists until d_valid.

Structure
REQ-033 State enum typedef and TL-UL size constant SHALL live in student_pkg; opcodes taken from tlul_pkg.
REQ-034 No sub-module; single FSM plus capture registers and optional counter.

Verification
REQ-035 Write addr 0x4, wdata 0x1, be 0xF, device a_ready=1 -> a_opcode PutFullData, a_mask 0xF; AccessAck -> rsp_err_o=0, rsp_rdata_o=0.
REQ-036 Read addr 0x2 -> a_address 0x0, Get, mask 0xF; AccessAckData data 0x0000AFFE -> rsp_rdata_o=0x0000AFFE, err 0.
REQ-037 Write be 0x3, device stalls a_ready 5 cycles -> a_valid held, fields stable, PutPartialData mask 0x3.
REQ-038 Read returns d_error=1 or wrong d_source -> rsp_err_o=1, rsp_rdata_o=0.
REQ-039 rsp_ready_i low 4 cycles -> rsp_valid_o and data held, req_ready_o=0 throughout.
REQ-040 With TIMEOUT_EN, TimeoutCycles=8, no D beat -> rsp_err_o=1 exactly 8 cycles into WAIT; later beat discarded, next command correct.
